// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Provides operand width default, op encodings and the sequencer state type.
package mdu_pkg;

    localparam int unsigned MduWidth = 32;

    // op[1] selects divide, op[0] selects signed operation
    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// Combinational single iteration of the multiply/divide datapath.
// Ports:
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i    : upper half (product accumulator / partial remainder)
//   low_i    : lower half (multiplier being consumed / quotient being built)
//   opnd_i   : multiplicand or divisor magnitude
//   acc_o    : next upper half
//   low_o    : next lower half
module mdu_step
    import mdu_pkg::*;
#(
    parameter int unsigned Width = MduWidth
) (
    input  logic             is_div_i,
    input  logic [Width-1:0] acc_i,
    input  logic [Width-1:0] low_i,
    input  logic [Width-1:0] opnd_i,
    output logic [Width-1:0] acc_o,
    output logic [Width-1:0] low_o
);

    logic [Width:0]   mul_sum;
    logic [Width:0]   rem_sh;
    logic [Width+1:0] diff;

    always_comb begin
        mul_sum = {1'b0, acc_i} + (low_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh  = {acc_i, low_i[Width-1]};
        // One extra bit so a negative trial result is visible in the MSB
        diff    = {1'b0, rem_sh} - {2'b00, opnd_i};
        acc_o   = '0;
        low_o   = '0;
        if (is_div_i) begin
            if (!diff[Width+1]) begin
                acc_o = diff[Width-1:0];
                low_o = {low_i[Width-2:0], 1'b1};
            end else begin
                acc_o = rem_sh[Width-1:0];
                low_o = {low_i[Width-2:0], 1'b0};
            end
        end else begin
            acc_o = mul_sum[Width:1];
            low_o = {mul_sum[0], low_i[Width-1:1]};
        end
    end

    // A kept remainder is always below the divisor, so these top bits are zero
    logic unused_bits;
    assign unused_bits = ^{diff[Width], rem_sh[Width]};

endmodule

// File: rtl/mdu_controller.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// Runs 32 shift-add multiply or restoring-divide steps on operand magnitudes,
// then applies sign correction and writes HI/LO in a final fix-up cycle.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start, op, a, b  : launch request (sampled only when idle), op code, operands
//   hi_we, lo_we     : MTHI/MTLO strobes, honoured only when idle and not starting
//   wdata            : MTHI/MTLO data
//   busy             : operation in flight (stall request)
//   done             : one-cycle pulse when an operation updates HI/LO
//   hi, lo           : architectural HI/LO registers
module mdu_controller
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MduWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    mdu_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             neg_res_q, neg_res_d;   // product/quotient must be negated
    logic             neg_rem_q, neg_rem_d;   // remainder must be negated
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_acc, step_low;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] quot_s, rem_s;

    mdu_step #(
        .Width (WIDTH)
    ) u_step (
        .is_div_i (op_q[1]),
        .acc_i    (acc_q),
        .low_i    (low_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc),
        .low_o    (step_low)
    );

    always_comb begin
        a_neg  = op[0] & a[WIDTH-1];
        b_neg  = op[0] & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;

        prod   = {acc_q, low_q};
        prod_s = neg_res_q ? -prod : prod;
        quot_s = neg_res_q ? -low_q : low_q;
        rem_s  = neg_rem_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        a_orig_d  = a_orig_q;
        acc_d     = acc_q;
        low_d     = low_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StCalc;
                    op_d      = op;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = (b == '0);
                    a_orig_d  = a;
                    acc_d     = '0;
                    cnt_d     = '0;
                    if (op[1]) begin
                        low_d  = a_mag;
                        opnd_d = b_mag;
                    end else begin
                        low_d  = b_mag;
                        opnd_d = a_mag;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            StCalc: begin
                acc_d = step_acc;
                low_d = step_low;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = a_orig_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_s;
                    lo_d = quot_s;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_orig_q  <= '0;
            acc_q     <= '0;
            low_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            a_orig_q  <= a_orig_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
